hdmi_line_scheduler: RTL and testbench

- HDMI-domain read sequencer for the PPU-to-HDMI line ring buffer. The PPU-side writer fills one 256-pixel line per slot.
- Tracks line credits, picks the slot and pixel to read for each HDMI pixel (2x horizontal and vertical, centred with borders), and releases slots back to the writer.
- Detects underrun and overflow, and resynchronises at frame boundaries.
- Sits between the HDMI timing generator (hx/hy) and the line-buffer read port.

---
 rtl/hdmi_pkg.sv | 21 ++
 rtl/hdmi_line_scheduler_credit.sv | 50 +++++
 rtl/hdmi_line_scheduler.sv | 129 ++++++++++++
 tb/tb_hdmi_line_scheduler.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hdmi_pkg.sv
// Shared types and default geometry for the HDMI line-buffer read sequencer.
package hdmi_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FILL     = 2'd1,
    RUN      = 2'd2,
    UNDERRUN = 2'd3
  } sched_state_t;

  localparam int unsigned OSCREEN_WIDTH_DEF  = 720;
  localparam int unsigned OSCREEN_HEIGHT_DEF = 480;
  localparam int unsigned OFRAME_WIDTH_DEF   = 858;
  localparam int unsigned OFRAME_HEIGHT_DEF  = 525;
  localparam int unsigned ISCREEN_WIDTH_DEF  = 256;
  localparam int unsigned ISCREEN_HEIGHT_DEF = 240;
  localparam int unsigned HOFFSET_DEF        = 104;
  localparam int unsigned NBUF_DEF           = 4;
  localparam int unsigned PRIME_DEF          = 2;

endpackage

// File: rtl/hdmi_line_scheduler_credit.sv
// Up/down saturating credit counter with synchronous clear/preload and sticky overflow.
module line_credit_counter #(
  parameter int unsigned MAX = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       clr_i,
  input  logic                       set_i,
  input  logic                       inc_i,
  input  logic                       dec_i,
  output logic [$clog2(MAX+1)-1:0]   count_o,
  output logic [$clog2(MAX+1)-1:0]   count_next_o,
  output logic                       overflow_o
);

  localparam int unsigned CW = $clog2(MAX + 1);
  localparam logic [CW-1:0] MAX_C = CW'(MAX);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;

  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    // A clear preloads one credit when an increment lands in the same cycle.
    if (clr_i) begin
      cnt_d = set_i ? CW'(1) : '0;
    end else if (inc_i && !dec_i) begin
      if (cnt_q == MAX_C) ovf_d = 1'b1;
      else                cnt_d = cnt_q + CW'(1);
    end else if (dec_i && !inc_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign count_o      = cnt_q;
  assign count_next_o = cnt_d;
  assign overflow_o   = ovf_q;

endmodule

// File: rtl/hdmi_line_scheduler.sv
// HDMI-side read sequencer for the PPU line ring: credit tracking, 2x scaled
// slot/pixel selection inside a bordered window, slot release and error flags.
module hdmi_line_scheduler
  import hdmi_pkg::*;
#(
  parameter int unsigned ISCREEN_WIDTH  = ISCREEN_WIDTH_DEF,
  parameter int unsigned ISCREEN_HEIGHT = ISCREEN_HEIGHT_DEF,
  parameter int unsigned OSCREEN_HEIGHT = OSCREEN_HEIGHT_DEF,
  parameter int unsigned OFRAME_WIDTH   = OFRAME_WIDTH_DEF,
  parameter int unsigned OFRAME_HEIGHT  = OFRAME_HEIGHT_DEF,
  parameter int unsigned HOFFSET        = HOFFSET_DEF,
  parameter int unsigned NBUF           = NBUF_DEF,
  parameter int unsigned PRIME          = PRIME_DEF
) (
  input  logic                        clk_h,
  input  logic                        rst_h_n,
  input  logic [9:0]                  hx,
  input  logic [9:0]                  hy,
  input  logic                        line_ready,
  input  logic                        frame_start,
  output logic                        rd_en,
  output logic [$clog2(NBUF)-1:0]     rd_slot,
  output logic [7:0]                  rd_x,
  output logic                        pix_active,
  output logic                        line_release,
  output logic [1:0]                  state,
  output logic [$clog2(NBUF+1)-1:0]   credits,
  output logic                        underrun,
  output logic                        overflow
);

  localparam int unsigned SW = $clog2(NBUF);
  localparam int unsigned CW = $clog2(NBUF + 1);
  localparam int unsigned YA = (OSCREEN_HEIGHT < 2 * ISCREEN_HEIGHT) ? OSCREEN_HEIGHT
                                                                    : 2 * ISCREEN_HEIGHT;
  localparam logic [9:0]    X_LO    = 10'(HOFFSET);
  localparam logic [9:0]    X_HI    = 10'(HOFFSET + 2 * ISCREEN_WIDTH);
  localparam logic [9:0]    X_EOL   = 10'(OFRAME_WIDTH - 1);
  localparam logic [9:0]    Y_ACT   = 10'(YA);
  localparam logic [9:0]    Y_LAST  = 10'(OFRAME_HEIGHT - 1);
  localparam logic [CW-1:0] PRIME_C = CW'(PRIME);

  sched_state_t  state_q, state_d;
  logic [SW-1:0] rd_ptr_q, rd_ptr_d;
  logic [SW-1:0] rd_slot_q;
  logic [7:0]    rd_x_q, rd_x_d;
  logic          rd_en_q, rd_en_d;
  logic          rel_q, und_q, und_d;
  logic [CW-1:0] cred_q, cred_nxt;
  logic          ovf;

  logic       in_win, eol, run, rel, chk, clr;
  logic [9:0] y_nxt;

  assign in_win = (hy < Y_ACT) && (hx >= X_LO) && (hx < X_HI);
  assign eol    = (hx == X_EOL);
  assign run    = (state_q == RUN);
  assign rel    = eol && hy[0] && (hy < Y_ACT) && run;
  assign y_nxt  = (hy == Y_LAST) ? '0 : hy + 10'd1;
  // Underrun is judged at the end of the line preceding each new slot pair.
  assign chk    = eol && !y_nxt[0] && (y_nxt < Y_ACT);
  assign clr    = frame_start && !run;

  line_credit_counter #(.MAX(NBUF)) u_credit (
    .clk_i        (clk_h),
    .rst_ni       (rst_h_n),
    .clr_i        (clr),
    .set_i        (line_ready),
    .inc_i        (line_ready),
    .dec_i        (rel),
    .count_o      (cred_q),
    .count_next_o (cred_nxt),
    .overflow_o   (ovf)
  );

  always_ff @(posedge clk_h or negedge rst_h_n) begin
    if (!rst_h_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (frame_start) state_d = FILL;
      FILL:     if (!frame_start && eol && (hy == Y_LAST) && (cred_q >= PRIME_C)) state_d = RUN;
      RUN:      if (chk && (cred_nxt == '0)) state_d = UNDERRUN;
      UNDERRUN: if (frame_start) state_d = FILL;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    rd_en_d  = in_win && run;
    rd_x_d   = 8'((hx - X_LO) >> 1);
    und_d    = und_q | (run && (state_d == UNDERRUN));
    rd_ptr_d = rd_ptr_q;
    if (clr)      rd_ptr_d = '0;
    else if (rel) rd_ptr_d = rd_ptr_q + SW'(1);
  end

  always_ff @(posedge clk_h or negedge rst_h_n) begin
    if (!rst_h_n) begin
      rd_ptr_q  <= '0;
      rd_slot_q <= '0;
      rd_x_q    <= '0;
      rd_en_q   <= 1'b0;
      rel_q     <= 1'b0;
      und_q     <= 1'b0;
    end else begin
      rd_ptr_q  <= rd_ptr_d;
      rd_slot_q <= rd_ptr_q;
      rd_x_q    <= rd_x_d;
      rd_en_q   <= rd_en_d;
      rel_q     <= rel;
      und_q     <= und_d;
    end
  end

  assign rd_en        = rd_en_q;
  assign pix_active   = rd_en_q;
  assign rd_slot      = rd_slot_q;
  assign rd_x         = rd_x_q;
  assign line_release = rel_q;
  assign state        = state_q;
  assign credits      = cred_q;
  assign underrun     = und_q;
  assign overflow     = ovf;

endmodule

// File: tb/tb_hdmi_line_scheduler.sv
// Self-checking bench: compressed hx/hy sweeps, directed scenarios and random traffic
// compared every cycle against a behavioural model of the scheduler.
module tb_hdmi_line_scheduler;

  localparam int HOFF = 104, IW = 256, IH = 240, OH = 480, OW = 858, OFH = 525, NB = 4, PR = 2;

  logic       clk_h = 1'b0;
  logic       rst_h_n = 1'b0;
  logic [9:0] hx = '0, hy = '0;
  logic       line_ready = 1'b0, frame_start = 1'b0;
  logic       rd_en, pix_active, line_release, underrun, overflow;
  logic [1:0] rd_slot, state;
  logic [7:0] rd_x;
  logic [2:0] credits;

  int n_chk = 0, n_fail = 0;
  bit cmp_on = 1'b0;
  int slot104, pa104;
  int pts[10] = '{0, 103, 104, 105, 300, 614, 615, 616, 700, 857};

  always #5 clk_h = ~clk_h;

  hdmi_line_scheduler #(
    .ISCREEN_WIDTH(IW), .ISCREEN_HEIGHT(IH), .OSCREEN_HEIGHT(OH), .OFRAME_WIDTH(OW),
    .OFRAME_HEIGHT(OFH), .HOFFSET(HOFF), .NBUF(NB), .PRIME(PR)
  ) dut (
    .clk_h(clk_h), .rst_h_n(rst_h_n), .hx(hx), .hy(hy),
    .line_ready(line_ready), .frame_start(frame_start),
    .rd_en(rd_en), .rd_slot(rd_slot), .rd_x(rd_x), .pix_active(pix_active),
    .line_release(line_release), .state(state), .credits(credits),
    .underrun(underrun), .overflow(overflow)
  );

  // Behavioural model: mode 0 idle, 1 filling, 2 running, 3 underrun.
  typedef struct packed {
    int mode, cr, ptr, slot, x;
    bit und, ovf, rden, rel;
  } model_t;

  model_t m = '0;

  function automatic model_t model_step(model_t c, int x, int y, bit lr, bit fs);
    model_t n = c;
    bit win  = (y < OH) && (x >= HOFF) && (x < HOFF + 2 * IW);
    bit eol  = (x == OW - 1);
    bit rel  = eol && (y % 2 == 1) && (y < OH) && (c.mode == 2);
    int ny   = (y == OFH - 1) ? 0 : y + 1;
    int nc;
    n.rden = win && (c.mode == 2);
    n.x    = ((x - HOFF) / 2) % 256;
    n.slot = c.ptr;
    n.rel  = rel;
    if (fs && c.mode != 2) begin
      nc    = lr ? 1 : 0;
      n.ptr = 0;
    end else begin
      nc = c.cr + (lr ? 1 : 0) - (rel ? 1 : 0);
      if (nc > NB) begin nc = NB; n.ovf = 1'b1; end
      if (nc < 0) nc = 0;
      if (rel) n.ptr = (c.ptr + 1) % NB;
    end
    case (c.mode)
      0: if (fs) n.mode = 1;
      1: if (!fs && eol && y == OFH - 1 && c.cr >= PR) n.mode = 2;
      2: if (eol && ny % 2 == 0 && ny < OH && nc == 0) begin n.mode = 3; n.und = 1'b1; end
      3: if (fs) n.mode = 1;
      default: n.mode = 0;
    endcase
    n.cr = nc;
    return n;
  endfunction

  always @(posedge clk_h or negedge rst_h_n) begin
    if (!rst_h_n) m <= '0;
    else          m <= model_step(m, int'(hx), int'(hy), line_ready, frame_start);
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at t=%0t hx=%0d hy=%0d: got %0d expected %0d", nm, $time, hx, hy, act, exp);
    end
  endtask

  always @(negedge clk_h) begin
    if (cmp_on) begin
      chk("state", int'(state), m.mode);
      chk("credits", int'(credits), m.cr);
      chk("underrun", int'(underrun), int'(m.und));
      chk("overflow", int'(overflow), int'(m.ovf));
      chk("line_release", int'(line_release), int'(m.rel));
      chk("rd_en", int'(rd_en), int'(m.rden));
      chk("pix_active", int'(pix_active), int'(m.rden));
      if (m.rden) begin
        chk("rd_slot", int'(rd_slot), m.slot);
        chk("rd_x", int'(rd_x), m.x);
      end
    end
  end

  task automatic step(input int x, input int y, input bit lr, input bit fs);
    hx = 10'(x); hy = 10'(y); line_ready = lr; frame_start = fs;
    @(posedge clk_h);
    #1;
  endtask

  task automatic do_line(input int y, input int lr_hx, input int fs_hx, input bit rnd);
    for (int i = 0; i < 10; i++) begin
      step(pts[i], y, pts[i] == lr_hx, pts[i] == fs_hx);
      if (pts[i] == 104) begin slot104 = int'(rd_slot); pa104 = int'(pix_active); end
      if (rnd && i == 4) step(int'($urandom_range(0, OW - 1)), y, 1'b0, 1'b0);
    end
  endtask

  task automatic rnd_line(input int y, input int rate);
    int lr, fs;
    lr = (int'($urandom_range(0, 99)) < rate) ? pts[$urandom_range(0, 9)] : -1;
    fs = ($urandom_range(0, 99) < 4) ? pts[$urandom_range(0, 9)] : -1;
    do_line(y, lr, fs, 1'b1);
  endtask

  task automatic do_reset();
    rst_h_n = 1'b0;
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    rst_h_n = 1'b1;
    step(0, 0, 0, 0);
  endtask

  initial begin
    int exp_slot[4] = '{1, 2, 3, 0};
    int rate;

    step(0, 0, 0, 0); step(0, 0, 0, 0); step(0, 0, 0, 0);
    chk("rst_state", int'(state), 0);
    chk("rst_credits", int'(credits), 0);
    chk("rst_rd_en", int'(rd_en), 0);
    chk("rst_flags", int'({underrun, overflow, line_release}), 0);
    cmp_on  = 1'b1;
    rst_h_n = 1'b1;
    step(0, 500, 0, 0);

    // Prime and enter RUN at the frame wrap
    step(10, 500, 0, 1);
    chk("fill_entry", int'(state), 1);
    step(20, 505, 1, 0);
    step(20, 510, 1, 0);
    chk("fill_credits", int'(credits), 2);
    do_line(524, -1, -1, 1'b0);
    chk("run_entry", int'(state), 2);
    step(0, 0, 0, 0);
    step(103, 0, 0, 0);   chk("left_border", int'(rd_en), 0);
    step(104, 0, 0, 0);
    chk("first_rd_en", int'(rd_en), 1);
    chk("first_slot", int'(rd_slot), 0);
    chk("first_x", int'(rd_x), 0);
    step(615, 0, 0, 0);   chk("last_x", int'(rd_x), 255);
    step(616, 0, 0, 0);   chk("right_border", int'(rd_en), 0);
    step(857, 0, 0, 0);

    // Steady run: one credit per line pair, coincident ready+release on line 7
    do_line(1, -1, -1, 1'b0);
    chk("release_l1", int'(line_release), 1);
    chk("credits_l1", int'(credits), 1);
    for (int y = 2; y <= 7; y++) begin
      do_line(y, (y % 2 == 0) ? 0 : ((y == 7) ? 857 : -1), -1, 1'b0);
      if (y % 2 == 0) chk("slot_seq", slot104, exp_slot[y / 2 - 1]);
    end
    chk("coinc_release", int'(line_release), 1);
    chk("coinc_credits", int'(credits), 2);
    do_line(8, 0, 300, 1'b0);
    chk("slot_wrap", slot104, exp_slot[3]);
    chk("fs_ignored", int'(state), 2);
    chk("no_flags", int'({underrun, overflow}), 0);

    // Asynchronous reset mid-line
    step(300, 100, 0, 0);
    chk("pre_reset_rd_en", int'(rd_en), 1);
    #2 rst_h_n = 1'b0;
    #1;
    chk("async_zero", int'({rd_en, pix_active, rd_slot, rd_x, line_release, state,
                           credits, underrun, overflow}), 0);
    step(301, 100, 0, 0);
    step(302, 100, 0, 0);
    rst_h_n = 1'b1;
    step(303, 100, 0, 0);
    chk("post_reset_state", int'(state), 0);
    chk("post_reset_credits", int'(credits), 0);

    // Underrun: only three credits ever delivered
    step(0, 500, 0, 1);
    step(20, 510, 1, 0);
    step(20, 520, 1, 0);
    do_line(524, -1, -1, 1'b0);
    do_line(0, 0, -1, 1'b0);
    for (int y = 1; y <= 5; y++) do_line(y, -1, -1, 1'b0);
    chk("underrun_state", int'(state), 3);
    chk("underrun_flag", int'(underrun), 1);
    do_line(6, -1, -1, 1'b0);
    chk("underrun_black", pa104, 0);
    step(0, 9, 0, 1);
    chk("refill_state", int'(state), 1);
    chk("refill_credits", int'(credits), 0);

    // Overflow: five credits into four slots
    for (int i = 0; i < 5; i++) step(0, 10 + i, 1, 0);
    chk("ovf_credits", int'(credits), 4);
    chk("ovf_flag", int'(overflow), 1);
    do_line(524, -1, -1, 1'b0);
    do_line(0, -1, -1, 1'b0);
    do_line(1, 857, -1, 1'b0);
    chk("ovf_coinc_credits", int'(credits), 4);
    chk("ovf_coinc_release", int'(line_release), 1);
    chk("ovf_sticky", int'(overflow), 1);

    // Random traffic over compressed frames
    for (int f = 0; f < 30; f++) begin
      if (f % 10 == 0) begin
        do_reset();
        step(0, 520, 0, 1);
      end
      rate = int'($urandom_range(35, 75));
      for (int y = 0; y < 16; y++) rnd_line(y, rate);
      if ($urandom_range(0, 99) < 20) rnd_line(int'($urandom_range(0, OFH - 1)), rate);
      for (int y = 476; y < 482; y++) rnd_line(y, rate);
      for (int y = 520; y < OFH; y++) rnd_line(y, rate);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1);
  end

endmodule
